// File: rtl/vga_tile_renderer.sv
// vga_tile_renderer
//   Pixel stage behind the VGA timing counters. Each visible pixel is mapped onto
//   a 5x5 grid of CELL_W x CELL_H colour cells held in a writable pattern file.
//   Visible pixels that fall outside the grid are painted BORDER.
//
// Ports
//   clk, rst          pixel clock (rising edge), asynchronous active-high reset
//   h_count, v_count  raw counters from the timing stage
//   h_sync_in/v_sync_in sync strobes from the timing stage
//   wr_en/wr_x/wr_y/wr_data  pattern write port ({r,g,b}); out-of-grid writes are dropped
//   r, g, b           registered pixel colour
//   h_sync, v_sync    input syncs delayed by 2 cycles
//   de                display enable, aligned with r/g/b and the syncs
//
// Flow control: none. One pixel is accepted and one produced on every clock;
// every output is valid on every cycle, exactly 2 cycles after its inputs.
module vga_tile_renderer #(
    parameter int          H_START = 241,
    parameter int          H_END   = 1039,
    parameter int          V_START = 67,
    parameter int          V_END   = 665,
    parameter int          CELL_W  = 160,
    parameter int          CELL_H  = 120,
    parameter logic [11:0] BORDER  = 12'h00F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] h_count,
    input  logic [10:0] v_count,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    input  logic        wr_en,
    input  logic [2:0]  wr_x,
    input  logic [2:0]  wr_y,
    input  logic [11:0] wr_data,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b,
    output logic        h_sync,
    output logic        v_sync,
    output logic        de
);

    localparam logic [10:0] HS      = 11'(H_START);
    localparam logic [10:0] HE      = 11'(H_END);
    localparam logic [10:0] VS      = 11'(V_START);
    localparam logic [10:0] VE      = 11'(V_END);
    localparam logic [10:0] CW_LAST = 11'(CELL_W - 1);
    localparam logic [10:0] CH_LAST = 11'(CELL_H - 1);
    localparam logic [2:0]  OUTSIDE = 3'd5;   // column/row index meaning "past the grid"

    logic [10:0] sub_x, sub_x_n, sub_y, sub_y_n;
    logic [2:0]  col, col_n, row, row_n;
    logic        vis;

    logic [2:0]  col_s1, row_s1;
    logic        vis_s1, hs_s1, vs_s1;

    logic [11:0] pat [0:4][0:4];   // pat[row][col]
    logic [11:0] cell_rgb;

    // The tracker "next" values are the coordinates of the pixel being presented
    // this cycle, so stage 1 captures them directly.
    always_comb begin
        sub_x_n = sub_x;
        col_n   = col;
        if (h_count == HS) begin
            sub_x_n = '0;
            col_n   = '0;
        end else if (h_count > HS && h_count <= HE) begin
            if (sub_x == CW_LAST) begin
                sub_x_n = '0;
                col_n   = (col == OUTSIDE) ? OUTSIDE : col + 3'd1;
            end else begin
                sub_x_n = sub_x + 11'd1;
            end
        end
    end

    // Vertical tracker steps once per line, on the h_count == 0 cycle.
    always_comb begin
        sub_y_n = sub_y;
        row_n   = row;
        if (h_count == 11'd0) begin
            if (v_count == VS) begin
                sub_y_n = '0;
                row_n   = '0;
            end else if (v_count > VS && v_count <= VE) begin
                if (sub_y == CH_LAST) begin
                    sub_y_n = '0;
                    row_n   = (row == OUTSIDE) ? OUTSIDE : row + 3'd1;
                end else begin
                    sub_y_n = sub_y + 11'd1;
                end
            end
        end
    end

    assign vis = (h_count >= HS) && (h_count <= HE) && (v_count >= VS) && (v_count <= VE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_x  <= '0;
            col    <= '0;
            sub_y  <= '0;
            row    <= '0;
            col_s1 <= '0;
            row_s1 <= '0;
            vis_s1 <= 1'b0;
            hs_s1  <= 1'b0;
            vs_s1  <= 1'b0;
        end else begin
            sub_x  <= sub_x_n;
            col    <= col_n;
            sub_y  <= sub_y_n;
            row    <= row_n;
            col_s1 <= col_n;
            row_s1 <= row_n;
            vis_s1 <= vis;
            hs_s1  <= h_sync_in;
            vs_s1  <= v_sync_in;
        end
    end

    // Pattern file. Reads below see the pre-write value on a same-cycle hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++)
                    pat[i][j] <= (((i + j) % 2) == 0) ? 12'hFFF : 12'h000;
        end else if (wr_en) begin
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++)
                    if (wr_y == 3'(i) && wr_x == 3'(j))
                        pat[i][j] <= wr_data;
        end
    end

    always_comb begin
        cell_rgb = BORDER;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                if (row_s1 == 3'(i) && col_s1 == 3'(j))
                    cell_rgb = pat[i][j];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {r, g, b} <= '0;
            de        <= 1'b0;
            h_sync    <= 1'b0;
            v_sync    <= 1'b0;
        end else begin
            {r, g, b} <= vis_s1 ? cell_rgb : 12'h000;
            de        <= vis_s1;
            h_sync    <= hs_s1;
            v_sync    <= vs_s1;
        end
    end

endmodule

// File: tb/tb_vga_tile_renderer.sv
module tb_vga_tile_renderer;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] h_count, v_count;
    logic        h_sync_in, v_sync_in;
    logic        wr_en;
    logic [2:0]  wr_x, wr_y;
    logic [11:0] wr_data;
    logic [3:0]  r, g, b, s_r, s_g, s_b;
    logic        h_sync, v_sync, de, s_h_sync, s_v_sync, s_de;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    // entry: {due[31:0], chk, rgb[11:0], de, hs, vs, schk, srgb[11:0], sde}
    logic [61:0] exp_q[$];

    vga_tile_renderer dut (
        .clk(clk), .rst(rst), .h_count(h_count), .v_count(v_count),
        .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .r(r), .g(g), .b(b), .h_sync(h_sync), .v_sync(v_sync), .de(de)
    );

    vga_tile_renderer #(.CELL_W(4), .CELL_H(2)) dut_small (
        .clk(clk), .rst(rst), .h_count(h_count), .v_count(v_count),
        .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .r(s_r), .g(s_g), .b(s_b), .h_sync(s_h_sync), .v_sync(s_v_sync), .de(s_de)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: outputs are presented every cycle; pop entries that are due
    always @(negedge clk) begin
        while (exp_q.size() > 0 && int'(exp_q[0][61:30]) <= cyc) begin
            logic [61:0] e;
            e = exp_q.pop_front();
            if (e[29]) begin
                checks++;
                if ({r, g, b} !== e[28:17] || de !== e[16] || h_sync !== e[15] || v_sync !== e[14]) begin
                    errors++;
                    $display("FAIL main_px cyc=%0d got rgb=%h de=%b hs=%b vs=%b want rgb=%h de=%b hs=%b vs=%b",
                             cyc, {r, g, b}, de, h_sync, v_sync, e[28:17], e[16], e[15], e[14]);
                end
            end
            if (e[13]) begin
                checks++;
                if ({s_r, s_g, s_b} !== e[12:1] || s_de !== e[0]) begin
                    errors++;
                    $display("FAIL small_px cyc=%0d got rgb=%h de=%b want rgb=%h de=%b",
                             cyc, {s_r, s_g, s_b}, s_de, e[12:1], e[0]);
                end
            end
        end
    end

    // driver tasks
    task automatic drive(input int h, input int v, input logic hs, input logic vs,
                         input logic chk, input logic [11:0] e_rgb, input logic e_de,
                         input logic schk, input logic [11:0] s_rgb, input logic s_de_e);
        logic [31:0] due;
        @(posedge clk); #1;
        h_count   = 11'(h);
        v_count   = 11'(v);
        h_sync_in = hs;
        v_sync_in = vs;
        wr_en     = 1'b0;
        due       = 32'(cyc + 2);
        exp_q.push_back({due, chk, e_rgb, e_de, hs, vs, schk, s_rgb, s_de_e});
    endtask

    task automatic nx(input int h, input int v);
        drive(h, v, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0);
    endtask

    task automatic px(input int h, input int v, input logic [11:0] e_rgb, input logic e_de);
        drive(h, v, 1'b0, 1'b0, 1'b1, e_rgb, e_de, 1'b0, 12'h000, 1'b0);
    endtask

    task automatic write_cell(input logic [2:0] x, input logic [2:0] y, input logic [11:0] d);
        nx(0, 0);
        wr_en   = 1'b1;
        wr_x    = x;
        wr_y    = y;
        wr_data = d;
    endtask

    // frame start followed by line-start strobes up to v_last
    task automatic lines_to(input int v_last);
        nx(0, 67);
        for (int v = 68; v <= v_last; v++) nx(0, v);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({r, g, b, de, h_sync, v_sync} !== 16'h0 || {s_r, s_g, s_b, s_de} !== 13'h0) begin
            errors++;
            $display("FAIL %s got rgb=%h de=%b hs=%b vs=%b small rgb=%h de=%b want all 0",
                     name, {r, g, b}, de, h_sync, v_sync, {s_r, s_g, s_b}, s_de);
        end
    endtask

    initial begin
        rst = 1'b1; h_count = '0; v_count = '0; h_sync_in = 1'b0; v_sync_in = 1'b0;
        wr_en = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
        repeat (3) @(posedge clk);
        #1 check_zero("reset_state");
        rst = 1'b0;

        // row 0 line, both instances (small grid saturates after 20 pixels)
        nx(0, 67);
        for (int h = 240; h <= 1040; h++) begin
            if (h == 240)       px(h, 67, 12'h000, 1'b0);
            else if (h == 241)  drive(h, 67, 0, 0, 1, 12'hFFF, 1, 1, 12'hFFF, 1);
            else if (h == 245)  drive(h, 67, 0, 0, 0, 12'h000, 0, 1, 12'h000, 1);
            else if (h == 260)  drive(h, 67, 0, 0, 0, 12'h000, 0, 1, 12'hFFF, 1);
            else if (h == 261)  drive(h, 67, 0, 0, 0, 12'h000, 0, 1, 12'h00F, 1);
            else if (h == 300)  drive(h, 67, 0, 0, 0, 12'h000, 0, 1, 12'h00F, 1);
            else if (h == 400)  px(h, 67, 12'hFFF, 1'b1);
            else if (h == 401)  px(h, 67, 12'h000, 1'b1);
            else if (h == 561)  px(h, 67, 12'hFFF, 1'b1);
            else if (h == 1039) px(h, 67, 12'hFFF, 1'b1);
            else if (h == 1040) px(h, 67, 12'h000, 1'b0);
            else                nx(h, 67);
        end

        // row 1: colours inverted
        lines_to(187);
        for (int h = 241; h <= 561; h++) begin
            if (h == 241)      px(h, 187, 12'h000, 1'b1);
            else if (h == 401) px(h, 187, 12'hFFF, 1'b1);
            else if (h == 561) px(h, 187, 12'h000, 1'b1);
            else               nx(h, 187);
        end

        // blanking and sync delay
        px(100, 187, 12'h000, 1'b0);
        px(500, 20, 12'h000, 1'b0);
        drive(100, 20, 0, 0, 1, 12'h000, 0, 0, 12'h000, 0);
        drive(100, 20, 1, 0, 1, 12'h000, 0, 0, 12'h000, 0);
        drive(100, 20, 0, 1, 1, 12'h000, 0, 0, 12'h000, 0);
        drive(100, 20, 0, 1, 1, 12'h000, 0, 0, 12'h000, 0);
        drive(100, 20, 0, 0, 1, 12'h000, 0, 0, 12'h000, 0);

        // pattern writes: one out of range, one real
        write_cell(3'd5, 3'd0, 12'hF00);
        write_cell(3'd2, 3'd3, 12'hF00);
        lines_to(67);
        for (int h = 241; h <= 561; h++) begin
            if (h == 241)      px(h, 67, 12'hFFF, 1'b1);
            else if (h == 401) px(h, 67, 12'h000, 1'b1);
            else if (h == 561) px(h, 67, 12'hFFF, 1'b1);
            else               nx(h, 67);
        end
        lines_to(427);
        for (int h = 241; h <= 561; h++) begin
            if (h == 401)      px(h, 427, 12'hFFF, 1'b1);
            else if (h == 561) px(h, 427, 12'hF00, 1'b1);
            else               nx(h, 427);
        end

        // mid-line reset
        for (int h = 241; h <= 300; h++) nx(h, 427);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        #2 check_zero("async_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int h = 302; h <= 310; h++) nx(h, 427);
        lines_to(67);
        for (int h = 241; h <= 561; h++) begin
            if (h == 401)      px(h, 67, 12'h000, 1'b1);
            else if (h == 561) px(h, 67, 12'hFFF, 1'b1);
            else               nx(h, 67);
        end
        lines_to(427);
        for (int h = 241; h <= 561; h++) begin
            if (h == 561) px(h, 427, 12'h000, 1'b1);
            else          nx(h, 427);
        end

        repeat (4) nx(0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
